eth_rx_frame_buf: RTL and testbench
===================================

Name: eth_rx_frame_buf

Overview:
- Sits directly downstream of the RMII receiver and consumes its byte stream: rx_vld, rx_last, rx_err, rx_crc_ok and rx_data.
- Stores each frame in a byte RAM ring and filters it on destination MAC, length, CRC and error status.
- Commits good frames or rolls the write pointer back on bad ones.
- Replays committed frames, with the 4-byte FCS stripped, on a valid/ready byte stream for the CNN loader.

Parameters:
- DEPTH_LOG2, 11, data RAM is 2**DEPTH_LOG2 bytes; usable capacity is 2**DEPTH_LOG2-1.
- MAC_ADDR, 48'h02_00_00_00_00_01, station address; the first byte on the wire is MAC_ADDR[47:40].
- MIN_LEN, 64, minimum frame length in bytes, DA through FCS.
- MAX_LEN, 1518, maximum frame length in bytes, DA through FCS.
- GAP_CYCLES, 40, idle clocks without rx_vld that abort an open frame.
- LFIFO_LOG2, 3, depth of the committed-length FIFO is 2**LFIFO_LOG2 entries.

Ports:
- clk  in  1  system clock, 100 MHz.
- resetn  in  1  asynchronous active-low reset.
- rx_vld  in  1  byte strobe from the receiver; single-cycle; at most one per 8 clk.
- rx_last  in  1  qualifies rx_vld: this byte is the last of the frame, i.e. the final FCS byte.
- rx_err  in  1  sticky receiver error for the current frame.
- rx_crc_ok  in  1  FCS residue good; meaningful only with rx_vld&rx_last.
- rx_data  in  8  received byte.
- m_data  out  8  payload byte, DA through the end of payload; FCS excluded.
- m_vld  out  1  m_data is valid.
- m_last  out  1  last payload byte of the frame.
- m_rdy  in  1  consumer accepts the byte when m_vld&m_rdy.
- stat_ok  out  16  count of committed frames; wraps.
- stat_drop  out  16  count of dropped frames; wraps.

Behaviour:
- Reset, asynchronous on resetn=0:
  - Outputs m_vld=0, m_last=0, m_data=0, stat_ok=0, stat_drop=0.
  - All pointers=0, length FIFO empty, both FSMs in IDLE.
  - Reset mid-frame discards all stored data. No partial commit.
- Pointers (DEPTH_LOG2 bits, wrap modulo 2**DEPTH_LOG2):
  - wr_ptr is the write position.
  - cm_ptr is the commit point.
  - rd_ptr is the read position.
  - full = (wr_ptr+1 == rd_ptr).
- Writer FSM:
  - W_IDLE: the first rx_vld opens a frame. len=0, bad=0. Byte written at wr_ptr, then -> W_HDR.
  - W_HDR, bytes 0..5:
    - Each byte is compared to MAC_ADDR, MSB byte first.
    - Broadcast FF:FF:FF:FF:FF:FF also matches.
    - A mismatch sets bad. After byte 5 -> W_BODY.
  - W_BODY:
    - Each byte is written and increments len; len saturates at 2047.
    - If full, or len would exceed MAX_LEN, set bad and stop writing (-> W_DISC).
  - W_DISC: bytes are ignored until end of frame.
  - End of frame is rx_vld&rx_last in any non-idle state. Counting the last byte:
    - Accept iff ~bad & ~rx_err & rx_crc_ok & MIN_LEN<=len<=MAX_LEN & length FIFO not full.
    - Accept: push len into the length FIFO, cm_ptr<=wr_ptr+1 (including the last byte), stat_ok++.
    - Reject: wr_ptr<=cm_ptr, stat_drop++.
    - Either way -> W_IDLE.
  - Gap abort:
    - A counter is cleared on every rx_vld. If it reaches GAP_CYCLES while not W_IDLE: reject as above (rollback, stat_drop++), -> W_IDLE.
    - A frame opening while the length FIFO is full still rolls back at EOF.
- Reader FSM:
  - R_IDLE: when the length FIFO is non-empty, pop len, remaining=len-4 -> R_STREAM.
  - R_STREAM:
    - RAM read latency is 1 clk. Output uses a 2-entry skid so m_vld can stay high at 1 byte/clk.
    - First m_vld comes no later than 3 clk after commit.
    - m_data and m_last are held stable while m_vld&~m_rdy.
    - m_last=1 on byte remaining==1. After its handshake -> R_SKIP.
  - R_SKIP: rd_ptr+=4 in one cycle -> R_IDLE.
- Simultaneous events:
  - Commit and read in the same cycle are both honoured. The reader sees the new FIFO entry the next cycle.
  - Rollback never moves wr_ptr behind rd_ptr, because cm_ptr is never behind rd_ptr.
  - rx_vld arriving in the rollback cycle is impossible by upstream spacing and needs no handling.
- Counters are 16-bit and wrap from 65535 to 0.

Optional Feature:
- Macro: ETH_RX_PROMISC_EN.
- Defined: the DA comparison is removed and every frame passes the address check; the length/CRC/error checks still apply.
- Undefined: station-address or broadcast matching as above.

Decomposition:
- Package eth_pkg holds:
  - typedefs wr_state_t {W_IDLE,W_HDR,W_BODY,W_DISC} and rd_state_t {R_IDLE,R_STREAM,R_SKIP};
  - localparams ETH_FCS_LEN=4, ETH_DA_LEN=6, ETH_BCAST=48'hFFFF_FFFF_FFFF.
- One sub-module, eth_rx_len_fifo: synchronous FIFO of 11-bit lengths with push, pop, full, empty. The data RAM is inferred inline.

Test Plan:
- Good unicast, 64 bytes, DA=MAC_ADDR, crc_ok=1, m_rdy=1 -> exactly 60 m_vld bytes matching input bytes 0..59; m_last on byte 59; stat_ok=1.
- Same frame with crc_ok=0 at last -> no m_vld; stat_drop=1; wr_ptr restored. A following good frame streams intact.
- DA=02:00:00:00:00:02 -> dropped. Repeat with ETH_RX_PROMISC_EN defined -> 60 bytes output.
- Frame of 1519 bytes -> dropped. 63-byte frame -> dropped. Stop rx_vld after 20 bytes for 40 clk -> dropped with stat_drop++, and the next frame is accepted.
- m_rdy=0 while 9 good 64-byte frames arrive (DEPTH_LOG2=11) -> frames 1..8 committed, the 9th dropped (length FIFO full). Release m_rdy -> 8 frames in order, 480 bytes total.
- Deassert resetn mid-stream while m_vld=1 -> m_vld=0 immediately, counters 0; next good frame streams correctly.

Source files
------------

// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared types and constants for the Ethernet receive frame buffer
package eth_pkg;

  typedef enum logic [1:0] {W_IDLE, W_HDR, W_BODY, W_DISC} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_STREAM, R_SKIP} rd_state_t;

  localparam int          ETH_FCS_LEN = 4;
  localparam int          ETH_DA_LEN  = 6;
  localparam int          ETH_LEN_W   = 11;
  localparam logic [47:0] ETH_BCAST   = 48'hFFFF_FFFF_FFFF;

  // Byte idx of a 48-bit address in wire order (idx 0 is addr[47:40]).
  function automatic logic [7:0] da_byte(input logic [47:0] addr, input logic [2:0] idx);
    case (idx)
      3'd0:    da_byte = addr[47:40];
      3'd1:    da_byte = addr[39:32];
      3'd2:    da_byte = addr[31:24];
      3'd3:    da_byte = addr[23:16];
      3'd4:    da_byte = addr[15:8];
      default: da_byte = addr[7:0];
    endcase
  endfunction

endpackage

// File: rtl/eth_rx_len_fifo.sv
// rtl/eth_rx_len_fifo.sv - synchronous FIFO of committed frame lengths
// Head entry is visible combinationally while the FIFO is non-empty.
module eth_rx_len_fifo
  import eth_pkg::*;
#(
  parameter int W    = ETH_LEN_W,
  parameter int LOG2 = 3
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int DEPTH = 2**LOG2;
  localparam logic [LOG2:0] PTR_ONE = 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [LOG2:0] wp_q, wp_d;
  logic [LOG2:0] rp_q, rp_d;
  logic          do_push, do_pop;

  assign full_o  = (wp_q[LOG2] != rp_q[LOG2]) && (wp_q[LOG2-1:0] == rp_q[LOG2-1:0]);
  assign empty_o = (wp_q == rp_q);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rp_q[LOG2-1:0]];

  always_comb begin
    wp_d = wp_q;
    rp_d = rp_q;
    if (do_push) wp_d = wp_q + PTR_ONE;
    if (do_pop)  rp_d = rp_q + PTR_ONE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q[LOG2-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/eth_rx_frame_buf.sv
// rtl/eth_rx_frame_buf.sv - RMII byte-stream frame filter, ring buffer and FCS-stripping replay
// Define ETH_RX_PROMISC_EN to drop the destination-address filter.
module eth_rx_frame_buf
  import eth_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 11,
  parameter logic [47:0] MAC_ADDR   = 48'h02_00_00_00_00_01,
  parameter int          MIN_LEN    = 64,
  parameter int          MAX_LEN    = 1518,
  parameter int          GAP_CYCLES = 40,
  parameter int          LFIFO_LOG2 = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rx_vld,
  input  logic        rx_last,
  input  logic        rx_err,
  input  logic        rx_crc_ok,
  input  logic [7:0]  rx_data,
  output logic [7:0]  m_data,
  output logic        m_vld,
  output logic        m_last,
  input  logic        m_rdy,
  output logic [15:0] stat_ok,
  output logic [15:0] stat_drop
);

  localparam int DEPTH = 2**DEPTH_LOG2;
  localparam int GW    = $clog2(GAP_CYCLES + 1);

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [ETH_LEN_W-1:0]  len_t;

  localparam ptr_t          PTR_ONE = ptr_t'(1);
  localparam ptr_t          PTR_FCS = ptr_t'(ETH_FCS_LEN);
  localparam len_t          LEN_ONE = len_t'(1);
  localparam len_t          LEN_MIN = len_t'(MIN_LEN);
  localparam len_t          LEN_MAX = len_t'(MAX_LEN);
  localparam len_t          LEN_SAT = '1;
  localparam logic [GW-1:0] GAP_LIM = GW'(GAP_CYCLES);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] ram_q;

  ptr_t      wr_ptr_q, wr_ptr_d, cm_ptr_q, cm_ptr_d, rd_ptr_q, rd_ptr_d;
  wr_state_t ws_q, ws_d;
  len_t      wlen_q, wlen_d;
  logic      bad_q, bad_d, uc_miss_q, uc_miss_d, bc_miss_q, bc_miss_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [15:0]   ok_q, ok_d, drop_q, drop_d;

  logic wr_en, full, accept, opening;
  len_t len_cur, len_inc, len_new;
  logic bad_new, uc_new, bc_new;

  logic lf_push, lf_pop, lf_full, lf_empty;
  len_t lf_head;

  rd_state_t rs_q, rs_d;
  len_t      iss_rem_q, iss_rem_d;
  logic      issue, pop;
  logic [1:0] occ;
  logic      ram_vld_q, ram_vld_d, ram_last_q, ram_last_d;
  logic      mvld_q, mvld_d, mlast_q, mlast_d, sk_vld_q, sk_vld_d, sk_last_q, sk_last_d;
  logic [7:0] mdata_q, mdata_d, sk_data_q, sk_data_d;
  logic      out_last;

  assign full = ((wr_ptr_q + PTR_ONE) == rd_ptr_q);

  // ---------------- writer ----------------
  always_comb begin
    ws_d      = ws_q;
    wr_ptr_d  = wr_ptr_q;
    cm_ptr_d  = cm_ptr_q;
    wlen_d    = wlen_q;
    bad_d     = bad_q;
    uc_miss_d = uc_miss_q;
    bc_miss_d = bc_miss_q;
    gap_d     = gap_q;
    ok_d      = ok_q;
    drop_d    = drop_q;
    wr_en     = 1'b0;
    lf_push   = 1'b0;
    accept    = 1'b0;

    // A byte seen in W_IDLE starts from a clean per-frame context.
    opening = (ws_q == W_IDLE);
    len_cur = opening ? '0 : wlen_q;
    bad_new = opening ? 1'b0 : bad_q;
    uc_new  = opening ? 1'b0 : uc_miss_q;
    bc_new  = opening ? 1'b0 : bc_miss_q;
    len_inc = (len_cur == LEN_SAT) ? LEN_SAT : len_cur + LEN_ONE;
    len_new = len_cur;

    if (rx_vld)                 gap_d = '0;
    else if (gap_q != GAP_LIM)  gap_d = gap_q + GW'(1);

    if (ws_q != W_IDLE && gap_q == GAP_LIM) begin
      wr_ptr_d = cm_ptr_q;
      drop_d   = drop_q + 16'd1;
      ws_d     = W_IDLE;
    end else if (rx_vld) begin
      if (ws_q != W_DISC) begin
        if (full || len_inc > LEN_MAX) begin
          bad_new = 1'b1;
          ws_d    = W_DISC;
        end else begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_ONE;
          len_new  = len_inc;
          if (ws_q inside {W_IDLE, W_HDR}) begin
`ifdef ETH_RX_PROMISC_EN
            uc_new = 1'b0;
            bc_new = 1'b0;
`else
            if (rx_data != da_byte(MAC_ADDR, len_cur[2:0]))  uc_new = 1'b1;
            if (rx_data != da_byte(ETH_BCAST, len_cur[2:0])) bc_new = 1'b1;
`endif
            ws_d = (len_cur == len_t'(ETH_DA_LEN - 1)) ? W_BODY : W_HDR;
          end
        end
      end
      wlen_d    = len_new;
      bad_d     = bad_new;
      uc_miss_d = uc_new;
      bc_miss_d = bc_new;

      if (rx_last) begin
        accept = ~bad_new & ~(uc_new & bc_new) & ~rx_err & rx_crc_ok &
                 (len_new >= LEN_MIN) & (len_new <= LEN_MAX) & ~lf_full;
        if (accept) begin
          lf_push  = 1'b1;
          cm_ptr_d = wr_ptr_d;
          ok_d     = ok_q + 16'd1;
        end else begin
          wr_ptr_d = cm_ptr_q;
          drop_d   = drop_q + 16'd1;
        end
        ws_d = W_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ws_q      <= W_IDLE;
      wr_ptr_q  <= '0;
      cm_ptr_q  <= '0;
      wlen_q    <= '0;
      bad_q     <= 1'b0;
      uc_miss_q <= 1'b0;
      bc_miss_q <= 1'b0;
      gap_q     <= '0;
      ok_q      <= '0;
      drop_q    <= '0;
    end else begin
      ws_q      <= ws_d;
      wr_ptr_q  <= wr_ptr_d;
      cm_ptr_q  <= cm_ptr_d;
      wlen_q    <= wlen_d;
      bad_q     <= bad_d;
      uc_miss_q <= uc_miss_d;
      bc_miss_q <= bc_miss_d;
      gap_q     <= gap_d;
      ok_q      <= ok_d;
      drop_q    <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= rx_data;
    ram_q <= mem_q[rd_ptr_q];
  end

  eth_rx_len_fifo #(
    .W    (ETH_LEN_W),
    .LOG2 (LFIFO_LOG2)
  ) u_len_fifo (
    .clk         (clk),
    .resetn      (resetn),
    .push_i      (lf_push),
    .push_data_i (wlen_d),
    .pop_i       (lf_pop),
    .head_o      (lf_head),
    .full_o      (lf_full),
    .empty_o     (lf_empty)
  );

  // ---------------- reader ----------------
  // The head length stays queued until its frame is drained, so FIFO occupancy
  // equals the number of committed frames still held in the ring.
  always_comb begin
    rs_d       = rs_q;
    rd_ptr_d   = rd_ptr_q;
    iss_rem_d  = iss_rem_q;
    lf_pop     = 1'b0;
    issue      = 1'b0;
    pop        = mvld_q & m_rdy;
    occ        = {1'b0, mvld_q} + {1'b0, sk_vld_q} + {1'b0, ram_vld_q};

    case (rs_q)
      R_IDLE: begin
        if (!lf_empty) begin
          iss_rem_d = lf_head - len_t'(ETH_FCS_LEN);
          rs_d      = R_STREAM;
        end
      end
      R_STREAM: begin
        // Reads in flight plus buffered bytes never exceed the two output slots.
        if (iss_rem_q != '0 && (occ != 2'd2 || pop)) begin
          issue     = 1'b1;
          rd_ptr_d  = rd_ptr_q + PTR_ONE;
          iss_rem_d = iss_rem_q - LEN_ONE;
        end
        if (pop && mlast_q) rs_d = R_SKIP;
      end
      R_SKIP: begin
        rd_ptr_d = rd_ptr_q + PTR_FCS;
        lf_pop   = 1'b1;
        rs_d     = R_IDLE;
      end
      default: rs_d = R_IDLE;
    endcase

    ram_vld_d  = issue;
    ram_last_d = issue & (iss_rem_q == LEN_ONE);

    mvld_d    = mvld_q & ~pop;
    out_last  = mlast_q;
    mdata_d   = mdata_q;
    sk_vld_d  = sk_vld_q;
    sk_last_d = sk_last_q;
    sk_data_d = sk_data_q;
    if (!mvld_d && sk_vld_d) begin
      mvld_d   = 1'b1;
      out_last = sk_last_q;
      mdata_d  = sk_data_q;
      sk_vld_d = 1'b0;
    end
    if (ram_vld_q) begin
      if (!mvld_d) begin
        mvld_d   = 1'b1;
        out_last = ram_last_q;
        mdata_d  = ram_q;
      end else begin
        sk_vld_d  = 1'b1;
        sk_last_d = ram_last_q;
        sk_data_d = ram_q;
      end
    end
    mlast_d = mvld_d & out_last;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rs_q       <= R_IDLE;
      rd_ptr_q   <= '0;
      iss_rem_q  <= '0;
      ram_vld_q  <= 1'b0;
      ram_last_q <= 1'b0;
      mvld_q     <= 1'b0;
      mlast_q    <= 1'b0;
      mdata_q    <= '0;
      sk_vld_q   <= 1'b0;
      sk_last_q  <= 1'b0;
      sk_data_q  <= '0;
    end else begin
      rs_q       <= rs_d;
      rd_ptr_q   <= rd_ptr_d;
      iss_rem_q  <= iss_rem_d;
      ram_vld_q  <= ram_vld_d;
      ram_last_q <= ram_last_d;
      mvld_q     <= mvld_d;
      mlast_q    <= mlast_d;
      mdata_q    <= mdata_d;
      sk_vld_q   <= sk_vld_d;
      sk_last_q  <= sk_last_d;
      sk_data_q  <= sk_data_d;
    end
  end

  assign m_data    = mdata_q;
  assign m_vld     = mvld_q;
  assign m_last    = mlast_q;
  assign stat_ok   = ok_q;
  assign stat_drop = drop_q;

endmodule

// File: tb/tb_eth_rx_frame_buf.sv
// tb/tb_eth_rx_frame_buf.sv - directed scoreboard bench for eth_rx_frame_buf
// Expectations adapt when ETH_RX_PROMISC_EN is defined.
module tb_eth_rx_frame_buf;

  localparam logic [47:0] MAC   = 48'h02_00_00_00_00_01;
  localparam logic [47:0] OTHER = 48'h02_00_00_00_00_02;
  localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;

  logic        clk       = 1'b0;
  logic        resetn    = 1'b0;
  logic        rx_vld    = 1'b0;
  logic        rx_last   = 1'b0;
  logic        rx_err    = 1'b0;
  logic        rx_crc_ok = 1'b0;
  logic [7:0]  rx_data   = 8'h00;
  logic [7:0]  m_data;
  logic        m_vld;
  logic        m_last;
  logic        m_rdy     = 1'b1;
  logic [15:0] stat_ok;
  logic [15:0] stat_drop;

  always #5 clk = ~clk;

  eth_rx_frame_buf dut (
    .clk       (clk),
    .resetn    (resetn),
    .rx_vld    (rx_vld),
    .rx_last   (rx_last),
    .rx_err    (rx_err),
    .rx_crc_ok (rx_crc_ok),
    .rx_data   (rx_data),
    .m_data    (m_data),
    .m_vld     (m_vld),
    .m_last    (m_last),
    .m_rdy     (m_rdy),
    .stat_ok   (stat_ok),
    .stat_drop (stat_drop)
  );

  int         checks   = 0;
  int         errors   = 0;
  int         exp_ok   = 0;
  int         exp_drop = 0;
  int         rx_bytes = 0;
  int         base;
  logic [8:0] sb [$];
  logic [7:0] frm [$];
  logic       prev_stall = 1'b0;
  logic [8:0] prev_out   = '0;
  logic [8:0] exp_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on each handshake and checks stall stability.
  always @(negedge clk) begin
    if (!resetn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("hold", {22'd0, m_vld, m_last, m_data}, {22'd0, 1'b1, prev_out});
      if (m_vld && m_rdy) begin
        rx_bytes++;
        checks++;
        assert (sb.size() > 0) else begin
          errors++;
          $error("FAIL extra_byte observed %0h expected none", {m_last, m_data});
        end
        if (sb.size() > 0) begin
          exp_b = sb.pop_front();
          chk("byte", {23'd0, m_last, m_data}, {23'd0, exp_b});
        end
      end
      prev_stall = m_vld && !m_rdy;
      prev_out   = {m_last, m_data};
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last, input logic crc, input logic err);
    @(posedge clk); #1;
    rx_vld    = 1'b1;
    rx_data   = d;
    rx_last   = last;
    rx_crc_ok = crc & last;
    rx_err    = err;
    @(posedge clk); #1;
    rx_vld    = 1'b0;
    rx_last   = 1'b0;
    rx_crc_ok = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  task automatic build(input logic [47:0] da, input int n, input int seed);
    frm.delete();
    for (int i = 0; i < 6; i++) frm.push_back(da[47-8*i -: 8]);
    for (int i = 6; i < n; i++) frm.push_back(8'((seed * 31 + i * 7) & 255));
  endtask

  task automatic send_frame(input int n, input logic crc, input logic err, input logic expect_ok);
    if (expect_ok)
      for (int i = 0; i < n - 4; i++) sb.push_back({(i == n - 5), frm[i]});
    for (int i = 0; i < n; i++) send_byte(frm[i], (i == n - 1), crc, err);
    rx_err = 1'b0;
    if (expect_ok) exp_ok++;
    else           exp_drop++;
  endtask

  task automatic wait_drain(input string tag, input logic rand_rdy);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 4000) begin
      @(posedge clk); #1;
      if (rand_rdy) m_rdy = 1'($urandom_range(0, 1));
      n++;
    end
    m_rdy = 1'b1;
    tick(20);
    chk({tag, "_drain"}, sb.size(), 0);
  endtask

  task automatic stats(input string tag);
    chk({tag, "_stat_ok"}, {16'd0, stat_ok}, exp_ok);
    chk({tag, "_stat_drop"}, {16'd0, stat_drop}, exp_drop);
  endtask

  initial begin
    tick(3); #1;
    chk("rst_m_vld", {31'd0, m_vld}, 0);
    chk("rst_m_last", {31'd0, m_last}, 0);
    chk("rst_m_data", {24'd0, m_data}, 0);
    stats("rst");
    @(posedge clk); #1 resetn = 1'b1;
    tick(2);

    // good 64-byte unicast
    build(MAC, 64, 1);
    send_frame(64, 1'b1, 1'b0, 1'b1);
    wait_drain("good64", 1'b0);
    stats("good64");
    chk("good64_bytes", rx_bytes, 60);

    // bad FCS, then a good frame must stream intact
    build(MAC, 64, 2);
    send_frame(64, 1'b0, 1'b0, 1'b0);
    tick(20);
    stats("badcrc");
    build(MAC, 64, 3);
    send_frame(64, 1'b1, 1'b0, 1'b1);
    wait_drain("after_badcrc", 1'b0);
    stats("after_badcrc");

    // foreign destination address
    build(OTHER, 64, 4);
`ifdef ETH_RX_PROMISC_EN
    send_frame(64, 1'b1, 1'b0, 1'b1);
`else
    send_frame(64, 1'b1, 1'b0, 1'b0);
`endif
    wait_drain("other_da", 1'b0);
    stats("other_da");

    // broadcast accepted, receiver error dropped
    build(BCAST, 64, 5);
    send_frame(64, 1'b1, 1'b0, 1'b1);
    wait_drain("bcast", 1'b0);
    build(MAC, 64, 6);
    send_frame(64, 1'b1, 1'b1, 1'b0);
    wait_drain("rxerr", 1'b0);
    stats("rxerr");

    // length boundaries
    build(MAC, 1519, 7);
    send_frame(1519, 1'b1, 1'b0, 1'b0);
    wait_drain("len1519", 1'b0);
    stats("len1519");
    build(MAC, 63, 8);
    send_frame(63, 1'b1, 1'b0, 1'b0);
    wait_drain("len63", 1'b0);
    stats("len63");
    build(MAC, 1518, 9);
    send_frame(1518, 1'b1, 1'b0, 1'b1);
    wait_drain("len1518", 1'b0);
    stats("len1518");

    // gap abort after 20 bytes, then a good frame
    build(MAC, 64, 10);
    for (int i = 0; i < 20; i++) send_byte(frm[i], 1'b0, 1'b0, 1'b0);
    tick(60);
    exp_drop++;
    stats("gap");
    build(MAC, 64, 11);
    send_frame(64, 1'b1, 1'b0, 1'b1);
    wait_drain("after_gap", 1'b0);
    stats("after_gap");

    // nine frames with the consumer stalled: length FIFO fills at eight
    m_rdy = 1'b0;
    for (int f = 0; f < 9; f++) begin
      build(MAC, 64, 20 + f);
      send_frame(64, 1'b1, 1'b0, (f < 8));
    end
    stats("nine");
    base = rx_bytes;
    @(posedge clk); #1 m_rdy = 1'b1;
    wait_drain("nine", 1'b0);
    chk("nine_bytes", rx_bytes - base, 480);

    // two frames drained with a randomly toggling consumer
    m_rdy = 1'b0;
    build(MAC, 64, 40);
    send_frame(64, 1'b1, 1'b0, 1'b1);
    build(BCAST, 64, 41);
    send_frame(64, 1'b1, 1'b0, 1'b1);
    wait_drain("rand_rdy", 1'b1);
    stats("rand_rdy");

    // reset while m_vld is high
    m_rdy = 1'b0;
    build(MAC, 64, 50);
    send_frame(64, 1'b1, 1'b0, 1'b1);
    for (int n = 0; n < 20 && !m_vld; n++) @(negedge clk);
    chk("pre_reset_m_vld", {31'd0, m_vld}, 1);
    #2 resetn = 1'b0;
    #1;
    sb.delete();
    exp_ok   = 0;
    exp_drop = 0;
    chk("reset_m_vld", {31'd0, m_vld}, 0);
    stats("reset");
    tick(3);
    @(posedge clk); #1 resetn = 1'b1;
    m_rdy = 1'b1;
    build(MAC, 64, 51);
    send_frame(64, 1'b1, 1'b0, 1'b1);
    wait_drain("post_reset", 1'b0);
    stats("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
